arcade_input_hub: RTL
=====================

# arcade_input_hub

Parametrised player-input front end for the arcade cores. Merges the HPS joystick words and PS/2 key events into registered, active-low per-player control words for an N-player, B-button cabinet. Adds what the current per-core glue logic lacks: coin pulse stretching, frame-locked autofire and upright/cocktail routing. Sits between `hps_io` and the game core's INP/DSW sampling, clocked on `clk_sys`.

## Interface
- `NPLAYERS`, 2, number of players, 1..4
- `NBTN`, 2, fire buttons per player, 1..6
- `COIN_CYC`, 16'd48000, coin pulse length in `clk_sys` cycles, >=1
- `AF_DIV`, 2, autofire half-period in frames, 1..15

- `clk_sys`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `ps2_key`  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
- `joy_in`  in  16*NPLAYERS  pad p at [16p+15:16p]: [0]R [1]L [2]D [3]U [4+k] button k, [4+NBTN] start, [5+NBTN] coin
- `cabinet`  in  1  0 = upright (all controls OR'd into P1), 1 = cocktail
- `af_en`  in  NBTN  per-button autofire enable, shared by all players
- `vblank`  in  1  frame tick source for autofire
- `p_out_n`  out  (4+NBTN)*NPLAYERS  player p word ~{L,R,U,D,btn[NBTN-1:0]}
- `sys_out_n`  out  2*NPLAYERS  ~{coin[NPLAYERS-1:0], start[NPLAYERS-1:0]}
- `coin_any_n`  out  1  ~(OR of stretched coins)

## Operation
- Key decoder: `ps2_key` registered once; an event is a change of bit 10 against the previous registered value. On an event, the matching key latch is loaded with bit 9. Codes 0x75/0x72/0x6B/0x74 match regardless of bit 8; all others require bit 8 = 0.
- Key map P1: arrows U/D/L/R, 0x29 btn0, 0x14 btn1, 0x16 start, 0x2E coin. P2: 0x2D U, 0x2B D, 0x23 L, 0x34 R, 0x1C btn0, 0x1B btn1, 0x1E start, 0x36 coin. F1 (0x05) = P1 start+coin; F2 (0x06) = P2 start+coin. Keys for P2 are ignored when NPLAYERS=1. No keyboard source for P3/P4 or for button >=2.
- Raw per-player signal = key latch OR joystick bit.
- Routing: `cabinet`=0 -> P1 directions/buttons = OR over all players; P2..PN keep their own. `cabinet`=1 -> each player uses only its own sources. Start and coin are never merged.
- Autofire: frame counter advances on each vblank rising edge (vblank registered once). Phase bit toggles every AF_DIV frames. Button k output = raw & (af_en[k] ? phase : 1). Phase and counter are reset to 0; the phase therefore starts 0, and an autofire button held from reset stays released for the first AF_DIV frames.
- Coin stretcher, per player, states IDLE/PULSE: IDLE + raw coin rising edge -> PULSE, counter = COIN_CYC-1, coin asserted. PULSE decrements each cycle, returns to IDLE after the cycle where it reaches 0. Edges during PULSE are ignored (no retrigger). A coin held continuously produces one pulse. A new pulse needs a release and then a fresh press after IDLE.
- Outputs are the registered inverse of the routed, autofired, stretched signals.

## Timing
- Reset (async assert, sync-to-clock release irrelevant inside): all key latches 0, counters 0, coin FSMs IDLE; `p_out_n`, `sys_out_n`, `coin_any_n` all ones.
- Joystick -> output: 2 cycles (input reg, output reg).
- Key event -> output: 3 cycles (ps2 reg, latch, output reg).
- Coin press -> coin low: 3 cycles from `joy_in` or event edge; low for exactly COIN_CYC cycles.
- Simultaneous press and release events cannot occur (one event per toggle); simultaneous key and pad on the same signal are OR'd.
- Reset during PULSE aborts the pulse; the output returns high asynchronously.
- `cabinet` and `af_en` are sampled every cycle; a change takes effect on the next output register update, with no glitch beyond one cycle.

## Test plan
- Reset with all pads idle -> `p_out_n` all ones, `sys_out_n`=4'b1111, `coin_any_n`=1.
- NPLAYERS=2, NBTN=2: `ps2_key` toggle with code 0x029 pressed -> P1 word bit btn0 low 3 cycles later. Release event -> high again.
- `cabinet`=0, joy P2 U -> P1 U and P2 U both low. `cabinet`=1 -> only P2 U low.
- COIN_CYC=10: hold P1 coin 50 cycles -> coin[0] and `coin_any_n` low exactly 10 cycles, once. Release, press again -> second 10-cycle pulse.
- AF_DIV=2, af_en=2'b01, hold btn0 across 8 vblanks -> btn0 alternates low/high every 2 frames; btn1 held steady.
- Assert `reset` mid coin pulse -> `coin_any_n` high immediately. After release with coin still held, no new pulse until release and re-press.

Source files
------------

// File: rtl/arcade_input_hub.sv
// arcade_input_hub: merges HPS joystick words and PS/2 key events into
// registered active-low player controls with coin stretch and autofire.
module arcade_input_hub #(
   parameter int NPLAYERS = 2,
   parameter int NBTN     = 2,
   parameter int COIN_CYC = 48000,
   parameter int AF_DIV   = 2
) (
   input  logic                         clk_sys,
   input  logic                         reset,
   input  logic [10:0]                  ps2_key,
   input  logic [16*NPLAYERS-1:0]       joy_in,
   input  logic                         cabinet,
   input  logic [NBTN-1:0]              af_en,
   input  logic                         vblank,
   output logic [(4+NBTN)*NPLAYERS-1:0] p_out_n,
   output logic [2*NPLAYERS-1:0]        sys_out_n,
   output logic                         coin_any_n
);
   localparam int          W      = 4 + NBTN;
   localparam logic [15:0] CLOAD  = 16'(COIN_CYC - 1);
   localparam logic [3:0]  AFLAST = 4'(AF_DIV - 1);

   typedef enum logic {IDLE, PULSE} coin_st_t;

   logic [10:0]                   ps2_q;
   logic                          tgl_q;
   logic [1:0][8:0]               key_q, key_d;
   logic [NPLAYERS-1:0][NBTN+5:0] joy_q, joy_d;
   logic                          vb_q, vbp_q, phase_q;
   logic [3:0]                    fcnt_q;
   logic                          ready_q;
   logic [NPLAYERS-1:0]           cprev_q;
   coin_st_t                      cst_q [NPLAYERS];
   coin_st_t                      cst_d [NPLAYERS];
   logic [15:0]                   ccnt_q [NPLAYERS];
   logic [15:0]                   ccnt_d [NPLAYERS];

   logic                          unused_joy;
   logic                          kpr, kne;
   logic [NPLAYERS-1:0][3:0]      dir_raw, dir_rt;
   logic [NPLAYERS-1:0][NBTN-1:0] btn_raw, btn_rt;
   logic [NPLAYERS-1:0]           st_raw, cn_raw, coin_on;
   logic [W*NPLAYERS-1:0]         pw;

   assign unused_joy = ^joy_in;
   assign kpr = ps2_q[9];
   assign kne = ~ps2_q[8];

   // latch bits: [0]R [1]L [2]D [3]U [5:4] btn [6] start [7] coin [8] Fn
   always_comb begin
      key_d = key_q;
      if (ps2_q[10] != tgl_q) begin
         case (ps2_q[7:0])
            8'h74: key_d[0][0] = kpr;
            8'h6B: key_d[0][1] = kpr;
            8'h72: key_d[0][2] = kpr;
            8'h75: key_d[0][3] = kpr;
            8'h29: if (kne) key_d[0][4] = kpr;
            8'h14: if (kne) key_d[0][5] = kpr;
            8'h16: if (kne) key_d[0][6] = kpr;
            8'h2E: if (kne) key_d[0][7] = kpr;
            8'h05: if (kne) key_d[0][8] = kpr;
            8'h34: if (kne) key_d[1][0] = kpr;
            8'h23: if (kne) key_d[1][1] = kpr;
            8'h2B: if (kne) key_d[1][2] = kpr;
            8'h2D: if (kne) key_d[1][3] = kpr;
            8'h1C: if (kne) key_d[1][4] = kpr;
            8'h1B: if (kne) key_d[1][5] = kpr;
            8'h1E: if (kne) key_d[1][6] = kpr;
            8'h36: if (kne) key_d[1][7] = kpr;
            8'h06: if (kne) key_d[1][8] = kpr;
            default: ;
         endcase
      end
      if (NPLAYERS < 2) key_d[1] = '0;
   end

   always_comb begin
      for (int p = 0; p < NPLAYERS; p++) begin
         joy_d[p]   = joy_in[16*p +: NBTN+6];
         dir_raw[p] = joy_q[p][3:0];
         btn_raw[p] = joy_q[p][4 +: NBTN];
         st_raw[p]  = joy_q[p][4+NBTN];
         cn_raw[p]  = joy_q[p][5+NBTN];
         if (p < 2) begin
            dir_raw[p] = dir_raw[p] | key_q[1'(p)][3:0];
            btn_raw[p] = btn_raw[p]
                       | NBTN'({4'b0, key_q[1'(p)][5:4]});
            st_raw[p]  = st_raw[p] | key_q[1'(p)][6]
                       | key_q[1'(p)][8];
            cn_raw[p]  = cn_raw[p] | key_q[1'(p)][7]
                       | key_q[1'(p)][8];
         end
      end
   end

   // upright cabinets fold every pad into P1; start/coin stay separate
   always_comb begin
      dir_rt = dir_raw;
      btn_rt = btn_raw;
      if (!cabinet) begin
         for (int p = 1; p < NPLAYERS; p++) begin
            dir_rt[0] = dir_rt[0] | dir_raw[p];
            btn_rt[0] = btn_rt[0] | btn_raw[p];
         end
      end
      for (int p = 0; p < NPLAYERS; p++) begin
         btn_rt[p]      = btn_rt[p] & ~(af_en & {NBTN{~phase_q}});
         pw[W*p +: W]   = {dir_rt[p][1], dir_rt[p][0],
                           dir_rt[p][3], dir_rt[p][2], btn_rt[p]};
         coin_on[p]     = (cst_q[p] == PULSE);
      end
   end

   always_comb begin
      for (int p = 0; p < NPLAYERS; p++) begin
         cst_d[p]  = cst_q[p];
         ccnt_d[p] = ccnt_q[p];
         unique case (cst_q[p])
            IDLE: begin
               if (cn_raw[p] && !cprev_q[p]) begin
                  cst_d[p]  = PULSE;
                  ccnt_d[p] = CLOAD;
               end
            end
            PULSE: begin
               if (ccnt_q[p] == '0) cst_d[p] = IDLE;
               else ccnt_d[p] = ccnt_q[p] - 16'd1;
            end
         endcase
      end
   end

   // cprev_q starts high so a coin held through reset never fires
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ps2_q      <= '0;
         tgl_q      <= 1'b0;
         key_q      <= '0;
         joy_q      <= '0;
         vb_q       <= 1'b0;
         vbp_q      <= 1'b0;
         fcnt_q     <= '0;
         phase_q    <= 1'b0;
         ready_q    <= 1'b0;
         cprev_q    <= '1;
         for (int p = 0; p < NPLAYERS; p++) begin
            cst_q[p]  <= IDLE;
            ccnt_q[p] <= '0;
         end
         p_out_n    <= '1;
         sys_out_n  <= '1;
         coin_any_n <= 1'b1;
      end else begin
         ps2_q   <= ps2_key;
         tgl_q   <= ps2_q[10];
         key_q   <= key_d;
         joy_q   <= joy_d;
         vb_q    <= vblank;
         vbp_q   <= vb_q;
         if (vb_q && !vbp_q) begin
            if (fcnt_q == AFLAST) begin
               fcnt_q  <= '0;
               phase_q <= ~phase_q;
            end else begin
               fcnt_q  <= fcnt_q + 4'd1;
            end
         end
         ready_q <= 1'b1;
         cprev_q <= ready_q ? cn_raw : '1;
         for (int p = 0; p < NPLAYERS; p++) begin
            cst_q[p]  <= cst_d[p];
            ccnt_q[p] <= ccnt_d[p];
         end
         p_out_n    <= ~pw;
         sys_out_n  <= ~{coin_on, st_raw};
         coin_any_n <= ~|coin_on;
      end
   end
endmodule
